// File: rtl/local_port_rx_vc_buffer_if.sv
// Local-port receive link: device flit input, per-VC head view, dequeue request,
// credit return and error status.
interface local_port_rx_vc_buffer_if #(
  parameter int VC_NUM  = 2,
  parameter int FLIT_W  = 64,
  parameter int VC_ID_W = 1,
  parameter int CNT_W   = 2
);
  logic                     rx_flit_v_i;
  logic [VC_ID_W-1:0]       rx_flit_vc_id_i;
  logic [FLIT_W-1:0]        rx_flit_i;
  logic [VC_NUM-1:0]        vc_head_vld_o;
  logic [VC_NUM*FLIT_W-1:0] vc_head_flit_o;
  logic [VC_NUM*CNT_W-1:0]  vc_occupancy_o;
  logic                     deq_v_i;
  logic [VC_ID_W-1:0]       deq_vc_id_i;
  logic                     tx_lcrd_v_o;
  logic [VC_ID_W-1:0]       tx_lcrd_id_o;
  logic                     overflow_err_o;
  logic                     underflow_err_o;

  modport master (
    output rx_flit_v_i, rx_flit_vc_id_i, rx_flit_i, deq_v_i, deq_vc_id_i,
    input  vc_head_vld_o, vc_head_flit_o, vc_occupancy_o, tx_lcrd_v_o,
           tx_lcrd_id_o, overflow_err_o, underflow_err_o
  );

  modport slave (
    input  rx_flit_v_i, rx_flit_vc_id_i, rx_flit_i, deq_v_i, deq_vc_id_i,
    output vc_head_vld_o, vc_head_flit_o, vc_occupancy_o, tx_lcrd_v_o,
           tx_lcrd_id_o, overflow_err_o, underflow_err_o
  );
endinterface

// File: rtl/local_port_rx_vc_buffer.sv
// Per-VC flit FIFOs for the local input port; every accepted dequeue returns
// one credit for its VC on the following cycle.
module local_port_rx_vc_buffer #(
  parameter int VC_NUM   = 2,
  parameter int VC_DEPTH = 2,
  parameter int FLIT_W   = 64,
  parameter int VC_ID_W  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  parameter int CNT_W    = $clog2(VC_DEPTH + 1)
) (
  input logic                      clk,
  input logic                      rst,
  local_port_rx_vc_buffer_if.slave bus
);
  localparam int PTR_W = (VC_DEPTH > 1) ? $clog2(VC_DEPTH) : 1;

  logic [FLIT_W-1:0]  r_mem  [VC_NUM][VC_DEPTH];
  logic [PTR_W-1:0]   r_wptr [VC_NUM];
  logic [PTR_W-1:0]   r_rptr [VC_NUM];
  logic [CNT_W-1:0]   r_cnt  [VC_NUM];
  logic               r_lcrd_v;
  logic [VC_ID_W-1:0] r_lcrd_id;
  logic               r_ovf;
  logic               r_unf;

  logic [VC_NUM-1:0] w_enq_hit, w_deq_hit, w_enq_ok, w_deq_ok, w_full, w_empty;
  logic              w_ovf, w_unf;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(VC_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A full VC still accepts a flit when the same cycle dequeues from it.
  always_comb begin
    w_enq_hit = '0;
    w_deq_hit = '0;
    w_enq_ok  = '0;
    w_deq_ok  = '0;
    w_full    = '0;
    w_empty   = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      w_empty[v]   = (r_cnt[v] == '0);
      w_full[v]    = (r_cnt[v] == CNT_W'(VC_DEPTH));
      w_enq_hit[v] = bus.rx_flit_v_i && (32'(bus.rx_flit_vc_id_i) == v);
      w_deq_hit[v] = bus.deq_v_i && (32'(bus.deq_vc_id_i) == v);
      w_deq_ok[v]  = w_deq_hit[v] && !w_empty[v];
      w_enq_ok[v]  = w_enq_hit[v] && (!w_full[v] || w_deq_ok[v]);
    end
    // An id matching no VC leaves the hit vector empty and counts as an error.
    w_ovf = (|(w_enq_hit & w_full & ~w_deq_ok)) || (bus.rx_flit_v_i && !(|w_enq_hit));
    w_unf = (|(w_deq_hit & w_empty)) || (bus.deq_v_i && !(|w_deq_hit));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < VC_NUM; v++) begin
        r_wptr[v] <= '0;
        r_rptr[v] <= '0;
        r_cnt[v]  <= '0;
      end
      r_lcrd_v  <= 1'b0;
      r_lcrd_id <= '0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (w_enq_ok[v]) r_wptr[v] <= ptr_inc(r_wptr[v]);
        if (w_deq_ok[v]) r_rptr[v] <= ptr_inc(r_rptr[v]);
        case ({w_enq_ok[v], w_deq_ok[v]})
          2'b10:   r_cnt[v] <= r_cnt[v] + 1'b1;
          2'b01:   r_cnt[v] <= r_cnt[v] - 1'b1;
          default: r_cnt[v] <= r_cnt[v];
        endcase
      end
      r_lcrd_v <= |w_deq_ok;
      if (|w_deq_ok) r_lcrd_id <= bus.deq_vc_id_i;
      if (w_ovf) r_ovf <= 1'b1;
      if (w_unf) r_unf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < VC_NUM; v++) begin
      if (!rst && w_enq_ok[v]) r_mem[v][r_wptr[v]] <= bus.rx_flit_i;
    end
  end

  for (genvar g = 0; g < VC_NUM; g++) begin : g_vc_out
    assign bus.vc_head_vld_o[g]                     = !w_empty[g];
    assign bus.vc_head_flit_o[g*FLIT_W +: FLIT_W]   = r_mem[g][r_rptr[g]];
    assign bus.vc_occupancy_o[g*CNT_W +: CNT_W]     = r_cnt[g];
  end

  assign bus.tx_lcrd_v_o     = r_lcrd_v;
  assign bus.tx_lcrd_id_o    = r_lcrd_id;
  assign bus.overflow_err_o  = r_ovf;
  assign bus.underflow_err_o = r_unf;
endmodule

// File: tb/tb_local_port_rx_vc_buffer.sv
// Directed bench for local_port_rx_vc_buffer (2 VCs, depth 2, 64-bit flits).
module tb_local_port_rx_vc_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  local_port_rx_vc_buffer_if #(.VC_NUM(2), .FLIT_W(64), .VC_ID_W(1), .CNT_W(2)) bus ();

  local_port_rx_vc_buffer #(.VC_NUM(2), .VC_DEPTH(2), .FLIT_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic ev, input logic evc, input logic [63:0] d,
                       input logic dv, input logic dvc);
    bus.rx_flit_v_i     = ev;
    bus.rx_flit_vc_id_i = evc;
    bus.rx_flit_i       = d;
    bus.deq_v_i         = dv;
    bus.deq_vc_id_i     = dvc;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // 1: reset
    idle();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_vld", 64'(bus.vc_head_vld_o), 64'h0);
    chk("rst_lcrd_v", 64'(bus.tx_lcrd_v_o), 64'h0);
    chk("rst_occ", 64'(bus.vc_occupancy_o), 64'h0);
    chk("rst_ovf", 64'(bus.overflow_err_o), 64'h0);
    chk("rst_unf", 64'(bus.underflow_err_o), 64'h0);
    rst = 1'b0;

    // 2: two flits through VC1
    drive(1'b1, 1'b1, 64'hA1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 64'hA2, 1'b0, 1'b0);
    tick();
    chk("t2_vld", 64'(bus.vc_head_vld_o), 64'h2);
    chk("t2_occ1", 64'(bus.vc_occupancy_o[3:2]), 64'd2);
    chk("t2_head_a1", bus.vc_head_flit_o[127:64], 64'hA1);
    drive(1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
    tick();
    chk("t2_lcrd_v_a", 64'(bus.tx_lcrd_v_o), 64'h1);
    chk("t2_lcrd_id_a", 64'(bus.tx_lcrd_id_o), 64'h1);
    chk("t2_head_a2", bus.vc_head_flit_o[127:64], 64'hA2);
    chk("t2_occ1_b", 64'(bus.vc_occupancy_o[3:2]), 64'd1);
    tick();
    chk("t2_lcrd_v_b", 64'(bus.tx_lcrd_v_o), 64'h1);
    chk("t2_lcrd_id_b", 64'(bus.tx_lcrd_id_o), 64'h1);
    chk("t2_empty", 64'(bus.vc_head_vld_o), 64'h0);
    idle();
    tick();
    chk("t2_lcrd_off", 64'(bus.tx_lcrd_v_o), 64'h0);
    chk("t2_id_hold", 64'(bus.tx_lcrd_id_o), 64'h1);

    // 3: overflow on full VC0
    drive(1'b1, 1'b0, 64'h10, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 64'h11, 1'b0, 1'b0);
    tick();
    chk("t3_no_ovf_yet", 64'(bus.overflow_err_o), 64'h0);
    drive(1'b1, 1'b0, 64'h12, 1'b0, 1'b0);
    tick();
    idle();
    chk("t3_ovf", 64'(bus.overflow_err_o), 64'h1);
    chk("t3_occ0", 64'(bus.vc_occupancy_o[1:0]), 64'd2);
    chk("t3_head", bus.vc_head_flit_o[63:0], 64'h10);
    tick();
    chk("t3_ovf_sticky", 64'(bus.overflow_err_o), 64'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t3_ovf_clr", 64'(bus.overflow_err_o), 64'h0);

    // 4: enqueue + dequeue on a full VC0
    drive(1'b1, 1'b0, 64'h10, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 64'h11, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 64'h12, 1'b1, 1'b0);
    tick();
    idle();
    chk("t4_occ0", 64'(bus.vc_occupancy_o[1:0]), 64'd2);
    chk("t4_no_ovf", 64'(bus.overflow_err_o), 64'h0);
    chk("t4_lcrd_v", 64'(bus.tx_lcrd_v_o), 64'h1);
    chk("t4_lcrd_id", 64'(bus.tx_lcrd_id_o), 64'h0);
    chk("t4_head_11", bus.vc_head_flit_o[63:0], 64'h11);
    drive(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    tick();
    chk("t4_head_12", bus.vc_head_flit_o[63:0], 64'h12);
    chk("t4_occ0_b", 64'(bus.vc_occupancy_o[1:0]), 64'd1);
    tick();
    idle();
    chk("t4_vc0_empty", 64'(bus.vc_head_vld_o), 64'h0);

    // 5: dequeue empty VC1 while enqueuing to it
    drive(1'b1, 1'b1, 64'h33, 1'b1, 1'b1);
    tick();
    idle();
    chk("t5_unf", 64'(bus.underflow_err_o), 64'h1);
    chk("t5_no_lcrd", 64'(bus.tx_lcrd_v_o), 64'h0);
    chk("t5_head", bus.vc_head_flit_o[127:64], 64'h33);
    chk("t5_occ1", 64'(bus.vc_occupancy_o[3:2]), 64'd1);
    chk("t5_vld", 64'(bus.vc_head_vld_o), 64'h2);
    drive(1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
    tick();
    idle();
    chk("t5_drain_lcrd", 64'(bus.tx_lcrd_v_o), 64'h1);
    chk("t5_drained", 64'(bus.vc_head_vld_o), 64'h0);

    // 6: interleaved traffic, then reset with two flits held
    drive(1'b1, 1'b0, 64'h50, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 64'h51, 1'b1, 1'b0);
    chk("t6_h0_50", bus.vc_head_flit_o[63:0], 64'h50);
    tick();
    chk("t6_lcrd_id0a", 64'(bus.tx_lcrd_id_o), 64'h0);
    drive(1'b1, 1'b0, 64'h52, 1'b1, 1'b1);
    chk("t6_h1_51", bus.vc_head_flit_o[127:64], 64'h51);
    tick();
    chk("t6_lcrd_id1a", 64'(bus.tx_lcrd_id_o), 64'h1);
    drive(1'b1, 1'b1, 64'h53, 1'b1, 1'b0);
    chk("t6_h0_52", bus.vc_head_flit_o[63:0], 64'h52);
    tick();
    chk("t6_lcrd_id0b", 64'(bus.tx_lcrd_id_o), 64'h0);
    drive(1'b1, 1'b0, 64'h54, 1'b1, 1'b1);
    chk("t6_h1_53", bus.vc_head_flit_o[127:64], 64'h53);
    tick();
    chk("t6_lcrd_v", 64'(bus.tx_lcrd_v_o), 64'h1);
    drive(1'b1, 1'b1, 64'h55, 1'b0, 1'b0);
    tick();
    idle();
    chk("t6_h0_54", bus.vc_head_flit_o[63:0], 64'h54);
    chk("t6_h1_55", bus.vc_head_flit_o[127:64], 64'h55);
    chk("t6_occ", 64'(bus.vc_occupancy_o), 64'h5);
    chk("t6_no_ovf", 64'(bus.overflow_err_o), 64'h0);
    rst = 1'b1;
    drive(1'b1, 1'b1, 64'h77, 1'b1, 1'b0);
    tick();
    chk("t6_rst_occ", 64'(bus.vc_occupancy_o), 64'h0);
    chk("t6_rst_vld", 64'(bus.vc_head_vld_o), 64'h0);
    chk("t6_rst_lcrd", 64'(bus.tx_lcrd_v_o), 64'h0);
    chk("t6_rst_unf", 64'(bus.underflow_err_o), 64'h0);
    rst = 1'b0;
    idle();
    tick();
    chk("t6_post_lcrd", 64'(bus.tx_lcrd_v_o), 64'h0);
    chk("t6_post_occ", 64'(bus.vc_occupancy_o), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/local_port_rx_vc_buffer.md
Name: local_port_rx_vc_buffer

Overview:
Router-side receiver for the local-port credit-based flow-control link. The local device transmitter spends one credit per flit and tags the flit with a VC id. This block stores each incoming flit in a per-VC FIFO and presents each VC head to switch allocation. Each time a flit is dequeued, it returns exactly one credit for that VC (tx_lcrd_v/tx_lcrd_id), which the device-side credit counter consumes.

Parameters:
- VC_NUM, 2, number of VCs on this input port (QoS/RT VCs occupy the low indices).
- VC_DEPTH, 2, flit slots per VC; must equal the transmitter's initial credits per VC.
- FLIT_W, 64, flit payload width in bits.
- VC_ID_W, VC_NUM>1 ? $clog2(VC_NUM) : 1, VC index width.
- CNT_W, $clog2(VC_DEPTH+1), occupancy counter width.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset; synchronous, active-high.
- rx_flit_v_i, input, 1, flit valid from the local device.
- rx_flit_vc_id_i, input, VC_ID_W, VC the device charged the credit to.
- rx_flit_i, input, FLIT_W, flit payload.
- vc_head_vld_o, output, VC_NUM, per-VC head valid (VC non-empty).
- vc_head_flit_o, output, VC_NUM*FLIT_W, per-VC head flit; VC i occupies bits [i*FLIT_W +: FLIT_W].
- vc_occupancy_o, output, VC_NUM*CNT_W, per-VC flit count.
- deq_v_i, input, 1, switch allocation grants and dequeues one head.
- deq_vc_id_i, input, VC_ID_W, VC being dequeued.
- tx_lcrd_v_o, output, 1, credit return valid to the device.
- tx_lcrd_id_o, output, VC_ID_W, VC whose credit is returned.
- overflow_err_o, output, 1, sticky: a flit arrived to a full VC.
- underflow_err_o, output, 1, sticky: a dequeue targeted an empty VC.

Behaviour:
- Storage and pointers
  - Per VC: a VC_DEPTH-entry circular buffer, a write pointer, a read pointer and a CNT_W occupancy count.
  - Pointers wrap from VC_DEPTH-1 to 0. Non-power-of-2 depth is supported via explicit compare.
- Reset (synchronous, rst=1 at a clk edge)
  - All counts, pointers, tx_lcrd_v_o, tx_lcrd_id_o and both error flags clear to 0.
  - vc_head_vld_o=0. vc_head_flit_o content is don't-care while its valid bit is 0.
  - Reset mid-traffic discards all stored flits and any pending credit return. It drops all state, including the current cycle's enqueue/dequeue; the device resets alongside.
- Enqueue
  - When rx_flit_v_i=1 and VC[rx_flit_vc_id_i] is not full: write the flit at the write pointer, advance the pointer, count+1.
  - The flit is visible at the head with vc_head_vld_o=1 the cycle after the edge that captured it; there is no same-cycle bypass.
- Dequeue
  - When deq_v_i=1 and VC[deq_vc_id_i] count>0: advance the read pointer and decrement the count.
  - vc_head_flit_o is combinational from the read pointer. The next flit, or valid=0, appears after the edge.
- Credit return
  - Registered. tx_lcrd_v_o=1 with tx_lcrd_id_o=deq_vc_id_i in the cycle after an accepted dequeue; otherwise tx_lcrd_v_o=0.
  - At most one credit per cycle. Back-to-back dequeues give back-to-back credits.
  - tx_lcrd_id_o holds its last value when tx_lcrd_v_o=0.
- Simultaneous enqueue and dequeue
  - Different VCs: independent.
  - Same non-empty VC: count unchanged, both pointers advance.
  - Same VC while full: the dequeue frees a slot and the enqueue is accepted; count stays VC_DEPTH and no overflow is flagged.
  - Same VC while empty: the dequeue is rejected (underflow_err_o set), the enqueue is accepted, count becomes 1 and no credit is returned.
- Errors
  - Enqueue to a full VC without a same-cycle dequeue on that VC: the flit is dropped and overflow_err_o is set.
  - Dequeue of an empty VC: ignored, no credit, underflow_err_o is set.
  - Both error flags hold until reset. An id >= VC_NUM is treated as an error of the corresponding type and otherwise ignored.
- Invariant: count + credits held by the device + in-flight credits = VC_DEPTH per VC.

Test Plan:
1. Reset with rst=1 for 2 cycles → vc_head_vld_o=00, tx_lcrd_v_o=0, all occupancies 0, both error flags 0.
2. Enqueue 0xA1 then 0xA2 on VC1 in consecutive cycles; dequeue VC1 twice starting cycle 3 → heads appear in order 0xA1, 0xA2; tx_lcrd_v_o=1 with id=1 in cycles 4 and 5; VC1 empty afterwards.
3. VC_DEPTH=2: fill VC0 with 0x10 and 0x11, send 0x12 without a dequeue → 0x12 dropped, overflow_err_o=1, occupancy stays 2, head=0x10.
4. VC0 full (0x10, 0x11); in the same cycle enqueue 0x12 and dequeue VC0 → occupancy stays 2, no error, credit id=0 next cycle, head sequence 0x11 then 0x12.
5. Dequeue empty VC1 while enqueuing 0x33 to VC1 → underflow_err_o=1, tx_lcrd_v_o=0 next cycle, VC1 head=0x33, occupancy 1.
6. Interleave: enqueue VC0 and VC1 each cycle for 6 cycles, with dequeues alternating VC0/VC1, then assert rst with 2 flits still held → per-VC FIFO order preserved before reset; after reset all occupancies 0, no credit emitted in the cycle after reset.
